// File: rtl/life_grid_engine.sv
// Double-buffered Game of Life grid: a raster scan reads the displayed bank and
// writes the next generation into the scratch bank, then the two banks swap roles.
module life_grid_engine #(
   parameter int GRID_W = 80,
   parameter int GRID_H = 60
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        simulating,
   input  logic        step_tick,
   input  logic        toggle,
   input  logic        clear,
   input  logic [6:0]  cursorX,
   input  logic [5:0]  cursorY,
   input  logic [6:0]  gridX,
   input  logic [5:0]  gridY,
   output logic        cellState,
   output logic        busy,
   output logic        gen_done,
   output logic [15:0] generation
);
   localparam int CELLS = GRID_W * GRID_H;
   localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;

   state_t           state, state_next;
   logic [CELLS-1:0] bank0, bank1, act_bank;
   logic             active;
   logic [IDX_W-1:0] idx, rd_idx, tg_idx;
   logic [6:0]       scan_x;
   logic [5:0]       scan_y;
   logic [3:0]       n_count;
   logic             next_cell, start, toggle_ok;

   // Off-grid coordinates read as dead, which gives the no-wrap boundary.
   function automatic logic cell_at(input logic [CELLS-1:0] b, input int x, input int y);
      logic [IDX_W-1:0] i;
      if (x < 0 || x >= GRID_W || y < 0 || y >= GRID_H) return 1'b0;
      i = IDX_W'(y * GRID_W + x);
      return b[i];
   endfunction

   assign act_bank = active ? bank1 : bank0;
   assign busy     = (state != IDLE);
   assign rd_idx   = IDX_W'(int'(gridY) * GRID_W + int'(gridX));
   assign tg_idx   = IDX_W'(int'(cursorY) * GRID_W + int'(cursorX));
   assign start    = (state == IDLE) && step_tick && simulating && !clear;
   assign toggle_ok = (state == IDLE) && toggle && !simulating && !clear &&
                      (int'(cursorX) < GRID_W) && (int'(cursorY) < GRID_H);

   always_comb begin
      cellState = 1'b0;
      if (int'(gridX) < GRID_W && int'(gridY) < GRID_H) cellState = act_bank[rd_idx];
   end

   always_comb begin
      n_count = '0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++)
            if (dx != 0 || dy != 0)
               n_count = n_count + 4'(cell_at(act_bank, int'(scan_x) + dx, int'(scan_y) + dy));
      next_cell = (n_count == 4'd3) ||
                  (cell_at(act_bank, int'(scan_x), int'(scan_y)) && (n_count == 4'd2));
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SCAN;
         SCAN:    if (clear) state_next = IDLE;
                  else if (idx == IDX_W'(CELLS - 1)) state_next = SWAP;
         SWAP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bank0      <= '0;
         bank1      <= '0;
         active     <= 1'b0;
         idx        <= '0;
         scan_x     <= '0;
         scan_y     <= '0;
         gen_done   <= 1'b0;
         generation <= '0;
      end else begin
         state    <= state_next;
         gen_done <= 1'b0;
         if (clear) begin
            // Clear wins over toggle, step and an in-flight scan or swap.
            if (active) bank1 <= '0;
            else        bank0 <= '0;
            generation <= '0;
            idx        <= '0;
            scan_x     <= '0;
            scan_y     <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (toggle_ok) begin
                     if (active) bank1[tg_idx] <= ~bank1[tg_idx];
                     else        bank0[tg_idx] <= ~bank0[tg_idx];
                  end
               end
               SCAN: begin
                  if (active) bank0[idx] <= next_cell;
                  else        bank1[idx] <= next_cell;
                  if (idx == IDX_W'(CELLS - 1)) begin
                     idx    <= '0;
                     scan_x <= '0;
                     scan_y <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                     if (int'(scan_x) == GRID_W - 1) begin
                        scan_x <= '0;
                        scan_y <= scan_y + 1'b1;
                     end else begin
                        scan_x <= scan_x + 1'b1;
                     end
                  end
               end
               SWAP: begin
                  active     <= ~active;
                  generation <= generation + 16'd1;
                  gen_done   <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: expected gen_done cycle and generation are
// queued at each step and checked by a monitor whenever gen_done fires.
module tb_life_grid_engine;
   localparam int W = 80, H = 60, N = W * H, LAT = N + 1;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        simulating = 1'b0, step_tick = 1'b0, toggle = 1'b0, clear = 1'b0;
   logic [6:0]  cursorX = '0, gridX = '0;
   logic [5:0]  cursorY = '0, gridY = '0;
   logic        cellState, busy, gen_done;
   logic [15:0] generation;

   int          vectors = 0, miscompares = 0, cyc = 0, n;
   logic [47:0] exp_q[$];
   logic [47:0] mon_e;

   life_grid_engine #(.GRID_W(W), .GRID_H(H)) dut (
      .clk(clk), .rst_n(rst_n), .simulating(simulating), .step_tick(step_tick),
      .toggle(toggle), .clear(clear), .cursorX(cursorX), .cursorY(cursorY),
      .gridX(gridX), .gridY(gridY), .cellState(cellState), .busy(busy),
      .gen_done(gen_done), .generation(generation)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: each gen_done must match the oldest queued {cycle, generation}.
   always @(negedge clk) begin
      if (rst_n && gen_done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_gen_done", 32'(gen_done), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("gen_done_cycle", cyc, mon_e[47:16]);
            check("generation_at_done", 32'(generation), 32'(mon_e[15:0]));
         end
      end
   end

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_toggle(input int x, input int y);
      sync();
      cursorX = 7'(x); cursorY = 6'(y); toggle = 1'b1;
      tick(1);
      toggle = 1'b0;
   endtask

   task automatic pulse_clear(input bit with_toggle, input bit with_step);
      sync();
      clear = 1'b1; toggle = with_toggle; step_tick = with_step;
      tick(1);
      clear = 1'b0; toggle = 1'b0; step_tick = 1'b0;
   endtask

   task automatic do_step(input bit expect_done, input logic [15:0] gen_exp);
      sync();
      step_tick = 1'b1;
      tick(1);
      step_tick = 1'b0;
      if (expect_done) exp_q.push_back({32'(cyc + LAT), gen_exp});
   endtask

   task automatic check_cell(input string name, input int x, input int y, input logic e);
      gridX = 7'(x); gridY = 6'(y);
      #1;
      check(name, 32'(cellState), 32'(e));
   endtask

   task automatic count_alive(output int cnt);
      cnt = 0;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            gridX = 7'(x); gridY = 6'(y);
            #1;
            if (cellState === 1'b1) cnt++;
         end
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (busy !== 1'b0 && t < 6000) begin
         tick(1);
         t++;
      end
      check({name, "_done_in_time"}, 32'(t < 6000), 32'd1);
      tick(2);
      check({name, "_pending_gen_done"}, exp_q.size(), 32'd0);
   endtask

   task automatic make_blinker();
      pulse_toggle(10, 10); pulse_toggle(11, 10); pulse_toggle(12, 10);
   endtask

   initial begin
      // Reset state
      tick(3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_gen_done", 32'(gen_done), 32'd0);
      check("rst_generation", 32'(generation), 32'd0);
      check_cell("rst_cell", 0, 0, 1'b0);
      rst_n = 1'b1;
      tick(2);

      // Edit gating
      simulating = 1'b1;
      pulse_toggle(5, 5);
      check_cell("toggle_in_run_mode", 5, 5, 1'b0);
      simulating = 1'b0;
      pulse_toggle(5, 5);
      check_cell("toggle_edit_set", 5, 5, 1'b1);
      pulse_toggle(5, 5);
      check_cell("toggle_edit_clr", 5, 5, 1'b0);
      pulse_toggle(80, 0);
      count_alive(n);
      check("oob_cursor_alive", n, 32'd0);

      // Blinker, two generations
      make_blinker();
      simulating = 1'b1;
      do_step(1'b1, 16'd1);
      check("busy_in_scan", 32'(busy), 32'd1);
      check_cell("stable_during_scan", 11, 9, 1'b0);
      wait_idle("blinker1");
      check_cell("blk1_11_9", 11, 9, 1'b1);
      check_cell("blk1_11_10", 11, 10, 1'b1);
      check_cell("blk1_11_11", 11, 11, 1'b1);
      check_cell("blk1_10_10", 10, 10, 1'b0);
      count_alive(n);
      check("blk1_alive", n, 32'd3);
      check("blk1_generation", 32'(generation), 32'd1);
      do_step(1'b1, 16'd2);
      wait_idle("blinker2");
      check_cell("blk2_10_10", 10, 10, 1'b1);
      check_cell("blk2_12_10", 12, 10, 1'b1);
      check_cell("blk2_11_9", 11, 9, 1'b0);
      check("blk2_generation", 32'(generation), 32'd2);

      // Clear in IDLE
      pulse_clear(1'b0, 1'b0);
      count_alive(n);
      check("idle_clear_alive", n, 32'd0);
      check("idle_clear_generation", 32'(generation), 32'd0);

      // Block still life at the corner, three steps
      simulating = 1'b0;
      pulse_toggle(0, 0); pulse_toggle(1, 0); pulse_toggle(0, 1); pulse_toggle(1, 1);
      simulating = 1'b1;
      for (int g = 1; g <= 3; g++) begin
         do_step(1'b1, 16'(g));
         wait_idle("block");
      end
      check_cell("block_0_0", 0, 0, 1'b1);
      check_cell("block_1_1", 1, 1, 1'b1);
      check_cell("block_no_wrap", 79, 59, 1'b0);
      check_cell("oob_read_x80", 80, 0, 1'b0);
      count_alive(n);
      check("block_alive", n, 32'd4);
      check("block_generation", 32'(generation), 32'd3);

      // Abort mid-scan with clear
      simulating = 1'b0;
      make_blinker();
      simulating = 1'b1;
      do_step(1'b0, 16'd0);
      tick(1998);
      pulse_clear(1'b0, 1'b0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_generation", 32'(generation), 32'd0);
      count_alive(n);
      check("abort_alive", n, 32'd0);
      tick(5000);

      // Clear with toggle, clear with step
      simulating = 1'b0;
      pulse_toggle(3, 3);
      cursorX = 7'd4; cursorY = 6'd4;
      pulse_clear(1'b1, 1'b0);
      count_alive(n);
      check("clear_toggle_alive", n, 32'd0);
      pulse_toggle(3, 3);
      simulating = 1'b1;
      pulse_clear(1'b0, 1'b1);
      check("clear_step_busy", 32'(busy), 32'd0);
      check_cell("clear_step_cell", 3, 3, 1'b0);
      tick(20);

      // Extra step_tick during scan, then simulating dropped mid-scan
      simulating = 1'b0;
      make_blinker();
      simulating = 1'b1;
      do_step(1'b1, 16'd1);
      tick(100);
      step_tick = 1'b1;
      tick(1);
      step_tick = 1'b0;
      wait_idle("step_in_scan");
      tick(20);
      do_step(1'b1, 16'd2);
      tick(500);
      simulating = 1'b0;
      wait_idle("sim_dropped");
      check_cell("sim_drop_10_10", 10, 10, 1'b1);
      check_cell("sim_drop_11_9", 11, 9, 1'b0);
      check("sim_drop_generation", 32'(generation), 32'd2);

      // Reset mid-scan
      simulating = 1'b1;
      do_step(1'b0, 16'd0);
      tick(999);
      rst_n = 1'b0;
      tick(1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_generation", 32'(generation), 32'd0);
      rst_n = 1'b1;
      tick(1);
      count_alive(n);
      check("rst_mid_alive", n, 32'd0);
      tick(5000);
      check("rst_mid_busy_after", 32'(busy), 32'd0);

      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/life_grid_engine.md
LIFE_GRID_ENGINE -- requirements
Module: life_grid_engine

Interface
REQ-001 Parameter GRID_W, default 80: grid width in cells.
REQ-002 Parameter GRID_H, default 60: grid height in cells.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-004 Ports SHALL be exactly:
- clk  input  1  system/pixel clock
- rst_n  input  1  asynchronous active-low reset
- simulating  input  1  level; 1 = run mode, 0 = edit mode
- step_tick  input  1  one-cycle pulse requesting one generation
- toggle  input  1  one-cycle pulse; invert the cell under the cursor
- clear  input  1  one-cycle pulse; kill all cells
- cursorX  input  7  cursor column
- cursorY  input  6  cursor row
- gridX  input  7  renderer read column
- gridY  input  6  renderer read row
- cellState  output  1  state of cell (gridX, gridY) in the displayed bank
- busy  output  1  generation scan in progress
- gen_done  output  1  one-cycle pulse when a new generation becomes visible
- generation  output  16  completed-generation counter

Function
REQ-005 Storage SHALL be two banks of GRID_W*GRID_H bits; one bank register (active) SHALL select the displayed bank, and the other bank SHALL be the scratch bank.
REQ-006 cellState SHALL be combinational from the active bank, with zero cycles of latency from gridX/gridY; it SHALL be 0 when gridX>=GRID_W or gridY>=GRID_H.
REQ-007 The FSM SHALL have the states IDLE, SCAN and SWAP.
REQ-008 IDLE->SCAN SHALL occur on step_tick=1 with simulating=1; step_tick SHALL be ignored in SCAN and SWAP, and SHALL be ignored when simulating=0.
REQ-009 SCAN SHALL visit one cell per cycle in raster order (x fastest), indices 0..GRID_W*GRID_H-1; busy SHALL be 1 in SCAN and SWAP.
REQ-010 Per visited cell, the next state SHALL be (n==3) | (alive & n==2), where n is the 4-bit count of the 8 neighbours in the active bank, and the result SHALL be written to the same coordinate in the scratch bank.
REQ-011 Neighbours outside the grid SHALL count as dead (no wrap-around); corner cells have 3 real neighbours and edge cells have 5.
REQ-012 After the last cell the FSM SHALL enter SWAP for one cycle, in which it SHALL invert active, increment generation (mod 2^16) and assert gen_done for that one cycle, then return to IDLE.
REQ-013 Step latency SHALL be GRID_W*GRID_H+1 cycles from the step_tick edge to the gen_done pulse (4801 with the defaults); cellState SHALL change only at the swap edge.
REQ-014 A deassertion of simulating during SCAN SHALL NOT abort the step; the generation SHALL complete and swap.
REQ-015 toggle SHALL invert the active-bank cell at (cursorX, cursorY) only in IDLE with simulating=0; an out-of-range cursor SHALL give no write; toggle in any other case SHALL be ignored.
REQ-016 clear in IDLE SHALL zero the active bank in one cycle and reset generation to 0.
REQ-017 clear in SCAN or SWAP SHALL abort to IDLE, zero the active bank and reset generation to 0, with no swap and no gen_done.
REQ-018 When clear and toggle are asserted in the same cycle, clear SHALL win and the toggle SHALL be dropped.
REQ-019 When clear and step_tick are asserted in IDLE in the same cycle, clear SHALL win and no scan SHALL start.

Reset
REQ-020 While rst_n=0, the block SHALL hold both banks all zero, active=0, FSM=IDLE, scan index=0, busy=0, gen_done=0 and generation=0.
REQ-021 Assertion of rst_n mid-SCAN SHALL immediately abandon the step, with no swap and no gen_done after release.

Verification
REQ-022 The bench SHALL cover a blinker: toggle (10,10),(11,10),(12,10), then step_tick with simulating=1 -> gen_done 4801 cycles later, alive cells (11,9),(11,10),(11,11), generation=1; a second step restores the row, generation=2.
REQ-023 The bench SHALL cover a block still life: 2x2 at (0,0), 3 steps -> cells unchanged, generation=3, and nothing born at (79,59) (no wrap).
REQ-024 The bench SHALL cover edit gating: a toggle at (5,5) with simulating=1 -> no change; with simulating=0 -> cellState(5,5)=1 the cycle after, and a second toggle -> 0; a cursor at (80,0) -> no write.
REQ-025 The bench SHALL cover abort: a blinker, step, then clear at scan index 2000 -> busy=0 next cycle, all cells 0, generation=0, and no gen_done within 5000 cycles.
REQ-026 The bench SHALL cover simultaneous events: clear+toggle in the same cycle -> all 0; step_tick during SCAN -> exactly one gen_done; simulating dropped mid-scan -> the step still completes.
REQ-027 The bench SHALL cover reset mid-scan: rst_n pulsed low at index 1000 -> busy=0, all cells 0, generation=0, and no gen_done after release.
